// File: rtl/ps2_key_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_sequencer
// Brief    : Sequences a PS/2 byte receiver, decodes Set-2 prefixes and queues
//            key events in a small valid/ready FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_key_sequencer #(
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int RST_CYCLES     = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ps2_clk_i,
    input  logic       rx_flag_i,
    input  logic [7:0] rx_data_i,
    output logic       rx_rst_o,
    output logic       evt_valid_o,
    input  logic       evt_ready_i,
    output logic [7:0] evt_code_o,
    output logic       evt_ext_o,
    output logic       evt_release_o,
    output logic       overflow_o,
    output logic       timeout_o
);

    localparam int c_ADDR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W  = c_ADDR_W + 1;
    localparam int c_WD_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_RC_W   = $clog2(RST_CYCLES + 1);
    localparam logic [c_WD_W-1:0]  c_WD_LAST = c_WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_RC_W-1:0]  c_RC_LAST = c_RC_W'(RST_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EXT     = 3'd1,
        S_BRK     = 3'd2,
        S_EXT_BRK = 3'd3,
        S_SKIP    = 3'd4
    } state_t;

    logic r_ps2_s1, r_ps2_s2, r_ps2_d;
    logic r_flag_s1, r_flag_s2, r_flag_d;
    logic w_ps2_fall, w_flag_fall;
    logic [7:0] r_byte;
    logic       r_byte_stb;

    logic              r_wd_active;
    logic [c_WD_W-1:0] r_wd_cnt;
    logic              r_timeout;
    logic              r_rx_rst;
    logic [c_RC_W-1:0] r_rst_cnt;
    logic              w_wd_fire;

    state_t     r_state;
    logic [2:0] r_skip_cnt;
    logic       w_push;
    logic [9:0] w_push_data;
    logic       w_is_noise;

    logic [9:0]         r_mem [FIFO_DEPTH];
    logic [c_ADDR_W-1:0] r_wp, r_rp;
    logic [c_CNT_W-1:0]  r_count;
    logic               r_overflow;
    logic               w_full, w_empty, w_pop, w_wr;

    assign w_ps2_fall  = r_ps2_d & ~r_ps2_s2;
    assign w_flag_fall = r_flag_d & ~r_flag_s2;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ps2_s1   <= 1'b1;
            r_ps2_s2   <= 1'b1;
            r_ps2_d    <= 1'b1;
            r_flag_s1  <= 1'b0;
            r_flag_s2  <= 1'b0;
            r_flag_d   <= 1'b0;
            r_byte     <= 8'h00;
            r_byte_stb <= 1'b0;
        end else begin
            r_ps2_s1   <= ps2_clk_i;
            r_ps2_s2   <= r_ps2_s1;
            r_ps2_d    <= r_ps2_s2;
            r_flag_s1  <= rx_flag_i;
            r_flag_s2  <= r_flag_s1;
            r_flag_d   <= r_flag_s2;
            r_byte_stb <= w_flag_fall;
            if (w_flag_fall) begin
                r_byte <= rx_data_i;
            end
        end
    end

    // A completed byte always wins over a timeout landing on the same cycle.
    assign w_wd_fire = r_wd_active & ~r_byte_stb & (r_wd_cnt == c_WD_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wd_active <= 1'b0;
            r_wd_cnt    <= '0;
            r_timeout   <= 1'b0;
            r_rx_rst    <= 1'b0;
            r_rst_cnt   <= '0;
        end else begin
            r_timeout <= w_wd_fire;
            if (r_byte_stb || w_wd_fire) begin
                r_wd_active <= 1'b0;
                r_wd_cnt    <= '0;
            end else if (r_wd_active) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end else if (w_ps2_fall && !r_rx_rst) begin
                r_wd_active <= 1'b1;
                r_wd_cnt    <= '0;
            end

            if (w_wd_fire) begin
                r_rx_rst  <= 1'b1;
                r_rst_cnt <= c_RC_LAST;
            end else if (r_rx_rst) begin
                if (r_rst_cnt == '0) begin
                    r_rx_rst <= 1'b0;
                end else begin
                    r_rst_cnt <= r_rst_cnt - 1'b1;
                end
            end
        end
    end

    // Acknowledge, self-test and error bytes never become key events.
    assign w_is_noise = (r_byte == 8'hAA) || (r_byte == 8'hFA) || (r_byte == 8'hFE) ||
                        (r_byte == 8'hEE) || (r_byte == 8'h00) || (r_byte == 8'hFF);

    always_comb begin
        w_push      = 1'b0;
        w_push_data = {2'b00, r_byte};
        if (r_byte_stb) begin
            case (r_state)
                S_IDLE: begin
                    if (r_byte != 8'hE0 && r_byte != 8'hF0 && r_byte != 8'hE1 && !w_is_noise) begin
                        w_push = 1'b1;
                    end
                end
                S_EXT: begin
                    if (r_byte != 8'hF0) begin
                        w_push      = 1'b1;
                        w_push_data = {2'b10, r_byte};
                    end
                end
                S_BRK: begin
                    w_push      = 1'b1;
                    w_push_data = {2'b01, r_byte};
                end
                S_EXT_BRK: begin
                    w_push      = 1'b1;
                    w_push_data = {2'b11, r_byte};
                end
                default: begin
                    w_push = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_skip_cnt <= 3'd0;
        end else if (w_wd_fire) begin
            r_state    <= S_IDLE;
            r_skip_cnt <= 3'd0;
        end else if (r_byte_stb) begin
            case (r_state)
                S_IDLE: begin
                    if (r_byte == 8'hE0) begin
                        r_state <= S_EXT;
                    end else if (r_byte == 8'hF0) begin
                        r_state <= S_BRK;
                    end else if (r_byte == 8'hE1) begin
                        r_state    <= S_SKIP;
                        r_skip_cnt <= 3'd7;
                    end
                end
                S_EXT:     r_state <= (r_byte == 8'hF0) ? S_EXT_BRK : S_IDLE;
                S_BRK:     r_state <= S_IDLE;
                S_EXT_BRK: r_state <= S_IDLE;
                S_SKIP: begin
                    r_skip_cnt <= r_skip_cnt - 3'd1;
                    if (r_skip_cnt == 3'd1) begin
                        r_state <= S_IDLE;
                    end
                end
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    assign w_full  = (r_count == c_FULL);
    assign w_empty = (r_count == '0);
    assign w_pop   = ~w_empty & evt_ready_i;
    assign w_wr    = w_push & (~w_full | w_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wp       <= '0;
            r_rp       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wp] <= w_push_data;
                r_wp        <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            if (w_wr && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_wr && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign evt_valid_o                               = ~w_empty;
    assign {evt_ext_o, evt_release_o, evt_code_o}    = r_mem[r_rp];
    assign overflow_o                                = r_overflow;
    assign timeout_o                                 = r_timeout;
    assign rx_rst_o                                  = r_rx_rst;

endmodule
`default_nettype wire

// File: doc/ps2_key_sequencer.md
Name: ps2_key_sequencer

Overview:
Controller between the PS/2 byte receiver and the calculator key logic. It sequences the receiver: it synchronizes the receiver's frame flag, captures each completed byte and watches the PS/2 clock for stalled frames. A stalled frame causes a pulse on the receiver reset. Captured bytes pass through a Set-2 prefix decoder (E0 / F0 / E1), and the resulting key events are queued in a small FIFO with a valid/ready handshake.

Parameters:
TIMEOUT_CYCLES, 200000, clk_i cycles allowed from the first PS/2 clock falling edge of a frame to frame completion (2 ms at 100 MHz)
RST_CYCLES, 4, width in clk_i cycles of the rx_rst_o pulse
FIFO_DEPTH, 4, event FIFO entries; power of two, minimum 2

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous active-high reset
ps2_clk_i  in  1  raw PS/2 clock, monitored only
rx_flag_i  in  1  receiver frame flag (ps2_clk domain); its falling edge means rx_data_i holds a new byte
rx_data_i  in  8  receiver output byte; stable from rx_flag_i falling edge until the next frame completes
rx_rst_o  out  1  reset pulse to the receiver (active-high)
evt_valid_o  out  1  FIFO head valid
evt_ready_i  in  1  consumer accepts the head
evt_code_o  out  8  scan code of the head event
evt_ext_o  out  1  head event had an E0 prefix
evt_release_o  out  1  head event is a key release (F0)
overflow_o  out  1  sticky flag: an event was dropped because the FIFO was full
timeout_o  out  1  one-cycle pulse when a frame timeout fires

Behaviour:
- Reset: all outputs 0. rx_rst_o = 0. Decoder in IDLE. FIFO empty. Synchronizers cleared to 1 for ps2_clk and 0 for rx_flag.
- Synchronizers: two flip-flops on each of ps2_clk_i and rx_flag_i. Edges are detected on the synchronized value against a third registered copy.
- Byte capture: on a detected falling edge of synchronized rx_flag, register rx_data_i into byte_r. Assert byte_stb for exactly 1 cycle, in the cycle after detection. rx_data_i is sampled at detection time; it is stable by then.
- Frame watchdog:
  - A synchronized ps2_clk falling edge while the watchdog is idle starts a counter at 0.
  - byte_stb clears the counter and returns the watchdog to idle.
  - If the counter reaches TIMEOUT_CYCLES-1: pulse timeout_o for 1 cycle, drive rx_rst_o high for RST_CYCLES cycles, force the decoder to IDLE, and keep the watchdog idle.
  - PS/2 clock edges seen while rx_rst_o is high are ignored.
  - The FIFO is untouched by a timeout.
- Decoder FSM, advancing only on byte_stb:
  - IDLE:
    - E0 -> EXT.
    - F0 -> BRK.
    - E1 -> SKIP with skip_cnt = 7.
    - AA, FA, FE, EE, 00, FF -> discarded, stay IDLE.
    - Any other code -> push {ext=0, rel=0, code}, stay IDLE.
  - EXT: F0 -> EXT_BRK. Any other code -> push {1,0,code}, go to IDLE.
  - BRK: push {0,1,code}, go to IDLE.
  - EXT_BRK: push {1,1,code}, go to IDLE.
  - SKIP: decrement skip_cnt on each byte. Return to IDLE when it reaches 0; the Pause sequence produces no event.
- Push timing: an event is written into the FIFO on the same cycle as its byte_stb. It is visible on evt_* no earlier than the next cycle.
- FIFO:
  - Head is registered. evt_valid_o = not empty.
  - A pop happens when evt_valid_o & evt_ready_i.
  - A simultaneous push and pop when full succeeds: count is unchanged and nothing is dropped.
  - A push when full without a pop drops the new event and sets overflow_o. overflow_o clears only on rst_i.
  - Read and write pointers wrap modulo FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1.
  - evt_ready_i is ignored while the FIFO is empty.
- rst_i asserted mid-frame or mid-pulse: all state clears at once. rx_rst_o drops to 0.

Test Plan:
- Make then break: bytes 1C, F0, 1C with ready=1 -> two events {code=1C, ext=0, rel=0} then {1C, 0, 1}; evt_valid_o high for 1 cycle each.
- Extended release: bytes E0, F0, 75 -> single event {75, 1, 1}. Then bytes AA and FA -> no events.
- Pause: E1 14 77 E1 F0 14 F0 77 followed by 16 -> exactly one event {16, 0, 0}.
- Backpressure: ready=0, send 5 make codes 15, 1D, 24, 2D, 2C (FIFO_DEPTH=4) -> overflow_o=1, FIFO holds 15, 1D, 24, 2D. Raise ready -> those four popped in order, then evt_valid_o=0.
- Stalled frame: 3 ps2_clk falling edges, no rx_flag activity -> after TIMEOUT_CYCLES cycles (use 100 in sim) timeout_o pulses and rx_rst_o is high for exactly 4 cycles. Decoder sitting in BRK returns to IDLE: the next byte 1C yields {1C, 0, 0}.
- Async reset asserted during an rx_rst_o pulse with 2 events queued -> rx_rst_o, evt_valid_o and overflow_o go 0 immediately, without waiting for a clk_i edge.
